// File: rtl/multicycle_control_pkg.sv
// Shared types for the multicycle control unit: FSM states, trap causes,
// datapath select encodings and the control word driven to the datapath.
package multicycle_control_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD_IR, EXEC, MEM, TRAP} mstate_t;

  typedef enum logic [1:0] {NONE, ILLEGAL, IBUS_TIMEOUT, DBUS_TIMEOUT} trap_cause_t;

  typedef enum logic [1:0] {PC_SRC_PLUS4, PC_SRC_BRANCH, PC_SRC_JUMP} pc_src_t;

  typedef enum logic [1:0] {ALU_IN_A_RS1, ALU_IN_A_PC, ALU_IN_A_ZERO} alu_in_a_t;

  typedef enum logic {ALU_IN_B_RS2, ALU_IN_B_IMM} alu_in_b_t;

  typedef enum logic [1:0] {ALU_OP_ADD, ALU_OP_SUB, ALU_OP_FUNCT} alu_op_t;

  // The first four fields are gated by the FSM; the selects follow decode.
  typedef struct packed {
    logic      rb_store;
    logic      pc_load;
    logic      dbus_we;
    logic      dbus_re;
    pc_src_t   pc_src;
    alu_in_a_t alu_in_a;
    alu_in_b_t alu_in_b;
    alu_op_t   alu_op;
  } cu_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  function automatic cu_t cu_gate(input cu_t c, input logic commit, input logic in_mem);
    cu_t g;
    g          = c;
    g.rb_store = c.rb_store & commit;
    g.pc_load  = c.pc_load & commit;
    g.dbus_we  = c.dbus_we & (commit | in_mem);
    g.dbus_re  = c.dbus_re & (commit | in_mem);
    return g;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Opcode decoder: maps the RV32I base opcode to an ungated control word
// and flags anything outside the supported opcode set as illegal.
module cu_decode
  import multicycle_control_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  output cu_t        cu,
  output logic       illegal
);

  always_comb begin
    cu.rb_store = 1'b0;
    cu.pc_load  = 1'b0;
    cu.dbus_we  = 1'b0;
    cu.dbus_re  = 1'b0;
    cu.pc_src   = PC_SRC_PLUS4;
    cu.alu_in_a = ALU_IN_A_RS1;
    cu.alu_in_b = ALU_IN_B_RS2;
    cu.alu_op   = ALU_OP_ADD;
    illegal     = 1'b0;
    case (opcode)
      OPC_LUI: begin
        cu.rb_store = 1'b1;
        cu.alu_in_a = ALU_IN_A_ZERO;
        cu.alu_in_b = ALU_IN_B_IMM;
      end
      OPC_AUIPC: begin
        cu.rb_store = 1'b1;
        cu.alu_in_a = ALU_IN_A_PC;
        cu.alu_in_b = ALU_IN_B_IMM;
      end
      OPC_JAL: begin
        cu.rb_store = 1'b1;
        cu.pc_load  = 1'b1;
        cu.pc_src   = PC_SRC_JUMP;
        cu.alu_in_a = ALU_IN_A_PC;
        cu.alu_in_b = ALU_IN_B_IMM;
      end
      OPC_JALR: begin
        cu.rb_store = 1'b1;
        cu.pc_load  = 1'b1;
        cu.pc_src   = PC_SRC_JUMP;
        cu.alu_in_b = ALU_IN_B_IMM;
      end
      OPC_BRANCH: begin
        cu.pc_src  = PC_SRC_BRANCH;
        cu.pc_load = branch_taken;
        cu.alu_op  = ALU_OP_SUB;
      end
      OPC_LOAD: begin
        cu.rb_store = 1'b1;
        cu.dbus_re  = 1'b1;
        cu.alu_in_b = ALU_IN_B_IMM;
      end
      OPC_STORE: begin
        cu.dbus_we  = 1'b1;
        cu.alu_in_b = ALU_IN_B_IMM;
      end
      OPC_OP_IMM: begin
        cu.rb_store = 1'b1;
        cu.alu_in_b = ALU_IN_B_IMM;
        cu.alu_op   = ALU_OP_FUNCT;
      end
      OPC_OP: begin
        cu.rb_store = 1'b1;
        cu.alu_op   = ALU_OP_FUNCT;
      end
      OPC_MISC_MEM: begin
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control unit: fetch/decode/execute/memory sequencing with bus
// timeouts, stall handling, trap reporting and a retired-instruction counter.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 16,
  parameter int unsigned CNT_W        = 32,
  parameter bit          HALT_ON_TRAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             hold,
  output logic             ibus_req,
  input  logic             ibus_ack,
  output logic             dbus_req,
  input  logic             dbus_ack,
  output cu_t              active,
  output logic             load_ir,
  output logic             en_iaddr,
  output logic             enable_pc_counter,
  output logic             trap,
  output trap_cause_t      trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  mstate_t     state, state_nxt;
  logic [7:0]  wait_cnt, wait_nxt;
  logic        from_mem, from_mem_nxt;
  trap_cause_t cause_nxt;
  cu_t         dec;
  logic        illegal;
  logic        commit;
  logic        in_mem;

  cu_decode u_cu_decode (
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .cu           (dec),
    .illegal      (illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      from_mem   <= 1'b0;
      trap_cause <= NONE;
      instret    <= '0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      from_mem   <= from_mem_nxt;
      trap_cause <= cause_nxt;
      if (commit) instret <= instret + 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_nxt     = wait_cnt;
    from_mem_nxt = from_mem;
    cause_nxt    = trap_cause;
    ibus_req     = 1'b0;
    dbus_req     = 1'b0;
    load_ir      = 1'b0;
    en_iaddr     = 1'b0;
    commit       = 1'b0;
    in_mem       = 1'b0;
    trap         = 1'b0;
    case (state)
      IDLE: begin
        if (!hold) begin
          state_nxt = FETCH;
          wait_nxt  = '0;
        end
      end
      FETCH: begin
        // A hold deferred from the memory phase keeps the next fetch from starting.
        if (!(from_mem && hold)) begin
          from_mem_nxt = 1'b0;
          ibus_req     = 1'b1;
          en_iaddr     = 1'b1;
          if (ibus_ack) begin
            state_nxt = LOAD_IR;
          end else if (wait_cnt == WAIT_LAST) begin
            state_nxt = TRAP;
            cause_nxt = IBUS_TIMEOUT;
          end else begin
            wait_nxt = wait_cnt + 8'd1;
          end
        end
      end
      LOAD_IR: begin
        if (!hold) begin
          load_ir   = 1'b1;
          en_iaddr  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (!hold) begin
          if (illegal) begin
            state_nxt = TRAP;
            cause_nxt = ILLEGAL;
          end else if (dec.dbus_re || dec.dbus_we) begin
            state_nxt = MEM;
            wait_nxt  = '0;
          end else begin
            commit    = 1'b1;
            state_nxt = FETCH;
            wait_nxt  = '0;
          end
        end
      end
      MEM: begin
        dbus_req = 1'b1;
        in_mem   = 1'b1;
        if (dbus_ack) begin
          commit       = 1'b1;
          state_nxt    = FETCH;
          wait_nxt     = '0;
          from_mem_nxt = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = TRAP;
          cause_nxt = DBUS_TIMEOUT;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      TRAP: begin
        trap = 1'b1;
        if (!HALT_ON_TRAP) begin
          state_nxt = FETCH;
          wait_nxt  = '0;
          cause_nxt = NONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enable_pc_counter = commit;
  assign active            = cu_gate(dec, commit, in_mem);

endmodule
